// File: rtl/calc_pkg.sv
// Shared encodings and arithmetic helpers for calc_ctrl (CALC_MUL_EN selects hardware multiply).
// No logic of its own; purely types, constants and combinational helpers.
package calc_pkg;

  typedef enum logic [3:0] {
    CMD_ADD = 4'd10,
    CMD_SUB = 4'd11,
    CMD_MUL = 4'd12,
    CMD_EQ  = 4'd13,
    CMD_NEG = 4'd14,
    CMD_CLR = 4'd15
  } cmd_e;

  typedef enum logic [2:0] {
    ST_OP1,
    ST_OP2,
    ST_CALC,
    ST_RES,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    STAT_EDIT   = 2'b00,
    STAT_BUSY   = 2'b01,
    STAT_ERROR  = 2'b10,
    STAT_RESULT = 2'b11
  } status_e;

  localparam int MAG_W = 27;

  function automatic logic [31:0] max_val(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < digits; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    return v[31] ? -v : v;
  endfunction

  // Keeps the sign of the operand: -3 followed by 5 becomes -35.
  function automatic logic signed [31:0] append_digit(input logic signed [31:0] v,
                                                      input logic [3:0]        d);
    logic signed [31:0] d32;
    d32 = $signed({28'd0, d});
    return v[31] ? (v * 32'sd10 - d32) : (v * 32'sd10 + d32);
  endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier of two MAG_W-bit magnitudes, built only under CALC_MUL_EN.
// 1 load cycle + MAG_W iterations, done pulses with prod valid; start is not backpressured.
module calc_mul_seq
  import calc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MAG_W-1:0]     a,
  input  logic [MAG_W-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*MAG_W-1:0]   prod
);

  localparam int PROD_W = 2 * MAG_W;

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MAG_W-1:0]  mplier_q, mplier_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = PROD_W'(a);
      mplier_d = b;
      cnt_d    = 5'(MAG_W);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign prod = acc_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator command sequencer; CALC_MUL_EN adds the shift-add multiplier, else cmd 12 errors.
// Outputs registered (1 cycle); add/sub busy 1 cycle, mul busy MAG_W+1; cmd_ready low only in CALC.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  cmd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] value,
  output logic [1:0]  status
);

  localparam logic [31:0] MAX_VAL = max_val(DIGITS);
  localparam logic [3:0]  DIG_MAX = 4'(DIGITS);

  state_e             state_q, state_d;
  logic signed [31:0] a_q, a_d;
  logic signed [31:0] b_q, b_d;
  logic [3:0]         cnt_q, cnt_d;
  cmd_e               op_q, op_d;
  logic [31:0]        value_q, value_d;
  status_e            status_q, status_d;

  logic               accept;
  logic signed [31:0] addsub_res;
  logic signed [31:0] calc_res;
  logic               calc_ovf;
  logic               res_vld;

  assign accept     = cmd_valid && (state_q != ST_CALC);
  assign addsub_res = (op_q == CMD_SUB) ? (a_q - b_q) : (a_q + b_q);

`ifdef CALC_MUL_EN
  localparam int PROD_W = 2 * MAG_W;

  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [PROD_W-1:0]  mul_prod;
  logic signed [31:0] mul_res;
  logic               mul_ovf;

  calc_mul_seq u_mul (
    .clock (clock),
    .reset (reset),
    .start (mul_start),
    .a     (MAG_W'(mag32(a_q))),
    .b     (MAG_W'(mag32(b_q))),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // A and B are frozen during CALC, so the sign can be taken from them at completion.
  always_comb begin
    mul_ovf = mul_prod > PROD_W'(MAX_VAL);
    mul_res = (a_q[31] ^ b_q[31]) ? -$signed(mul_prod[31:0]) : $signed(mul_prod[31:0]);
  end
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    calc_res = addsub_res;
    calc_ovf = mag32(addsub_res) > MAX_VAL;
    res_vld  = 1'b1;
`ifdef CALC_MUL_EN
    mul_start = 1'b0;
    if (op_q == CMD_MUL) begin
      calc_res = mul_res;
      calc_ovf = mul_ovf;
      res_vld  = mul_done && !mul_busy;
    end
`endif

    if (state_q == ST_CALC) begin
      if (res_vld) begin
        cnt_d = '0;
        if (calc_ovf) begin
          a_d     = '0;
          state_d = ST_ERR;
        end else begin
          a_d     = calc_res;
          state_d = ST_RES;
        end
      end
    end else if (accept) begin
      if (cmd == CMD_CLR) begin
        state_d = ST_OP1;
        a_d     = '0;
        b_d     = '0;
        cnt_d   = '0;
        op_d    = CMD_ADD;
      end else if (state_q != ST_ERR) begin
        if (cmd < CMD_ADD) begin
          if (state_q == ST_RES) begin
            a_d     = $signed({28'd0, cmd});
            cnt_d   = 4'd1;
            state_d = ST_OP1;
          end else if (cnt_q < DIG_MAX) begin
            cnt_d = cnt_q + 4'd1;
            if (state_q == ST_OP1) a_d = append_digit(a_q, cmd);
            else                   b_d = append_digit(b_q, cmd);
          end
        end else if (cmd == CMD_EQ) begin
          if (state_q == ST_OP2) begin
            state_d = ST_CALC;
`ifdef CALC_MUL_EN
            mul_start = (op_q == CMD_MUL);
`endif
          end
        end else if (cmd == CMD_NEG) begin
          // Negate whatever is on the display: B once digits are typed, otherwise A.
          if (state_q == ST_OP2 && cnt_q != 4'd0) b_d = -b_q;
          else                                    a_d = -a_q;
        end else begin
`ifndef CALC_MUL_EN
          if (cmd == CMD_MUL) begin
            state_d = ST_ERR;
            a_d     = '0;
            b_d     = '0;
            cnt_d   = '0;
          end else
`endif
          begin
            op_d = cmd_e'(cmd);
            if (state_q != ST_OP2) begin
              b_d     = '0;
              cnt_d   = '0;
              state_d = ST_OP2;
            end
          end
        end
      end
    end

    case (state_d)
      ST_OP1: begin
        value_d  = a_d;
        status_d = STAT_EDIT;
      end
      ST_OP2: begin
        value_d  = (cnt_d != 4'd0) ? b_d : a_d;
        status_d = STAT_EDIT;
      end
      ST_CALC: begin
        value_d  = value_q;
        status_d = STAT_BUSY;
      end
      ST_RES: begin
        value_d  = a_d;
        status_d = STAT_RESULT;
      end
      default: begin
        value_d  = '0;
        status_d = STAT_ERROR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_OP1;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      op_q     <= CMD_ADD;
      value_q  <= '0;
      status_q <= STAT_EDIT;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      value_q  <= value_d;
      status_q <= status_d;
    end
  end

  assign cmd_ready = (state_q != ST_CALC);
  assign value     = value_q;
  assign status    = status_q;

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Command sequencer for the calculator. It accepts 4-bit keypad commands and builds two signed operands from decimal digits. It sequences the arithmetic and presents the current operand or result plus a 2-bit status to the display path inside `calc_top`. Multiplication runs on an iterative shift-add sub-unit; add and subtract complete in one cycle.

## Interface
- `DIGITS`, default 8: maximum decimal digits per operand (1..8); MAX_VAL = 10^DIGITS − 1.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd` in 4: command code. 0–9 digit, 10 add, 11 sub, 12 mul, 13 equals, 14 negate, 15 clear.
- `cmd_valid` in 1: `cmd` is valid this cycle.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`; low only in CALC.
- `value` out 32: signed two's-complement number to display.
- `status` out 2: 00 EDIT, 01 BUSY, 10 ERROR, 11 RESULT.

## Operation
- **States**
  - OP1: entering operand A.
  - OP2: entering operand B.
  - CALC: computing.
  - RES: result shown.
  - ERR: overflow or unsupported operation.
- **Reset**: state OP1, A=B=0, digit count=0, pending op=add, `value`=0, `status`=00, `cmd_ready`=1.
- **Digit d, in OP1 or OP2**
  - If count < DIGITS: operand = operand*10 ± d, with the sign of the operand preserved; count++.
  - If count = DIGITS: the digit is ignored.
- **Operator (10/11/12)**
  - In OP1 or RES: latch the op, B=0, count=0, go to OP2.
  - In OP2: replace the pending op; no compute.
- **Equals (13)**
  - In OP2: go to CALC.
  - In OP1 or RES: no effect.
- **Negate (14)**: negates the operand being displayed. In RES it negates A, which holds the result.
- **Digit in RES**: A=d, count=1, go to OP1.
- **Clear (15)**: from any state except CALC, returns to reset values.
- **CALC**
  - Add/sub: one cycle.
  - Mul: magnitudes of A and B go to `calc_mul_seq`; the sign is the XOR of the operand signs.
  - On completion, if |result| > MAX_VAL: go to ERR with A=0.
  - Otherwise A=result, count=0, go to RES.
- **ERR**: every command is ignored except clear.
- **`value` per state**
  - OP1 shows A.
  - OP2 shows B if count>0, else A.
  - CALC holds the previous value.
  - RES shows A.
  - ERR shows 0.
- **`status` per state**: OP1/OP2 → 00, CALC → 01, RES → 11, ERR → 10.

## Timing
- Every command takes effect at the accepting edge; `value` and `status` are registered and update the following cycle.
- **Add/sub**: equals accepted at edge k. `status`=01 in cycle k+1. Result and `status`=11 (or 10) appear from k+2.
- **Mul**: `status`=01 for exactly MAG_W+1 = 28 cycles (1 load + 27 iterations). The result appears on the cycle after.
- `cmd_valid` while `cmd_ready`=0 is dropped, not queued.
- The multiplier accumulator is 2·MAG_W bits wide, so overflow is detected without wrap.
- The A/B registers never exceed ±MAX_VAL.
- Asserting `reset` during CALC aborts the multiply immediately; outputs return to reset values with no clock edge needed.

## Configuration
- Macro: `CALC_MUL_EN`.
- **Defined**: `calc_mul_seq` is instantiated and cmd 12 multiplies as above.
- **Undefined**
  - No multiplier hardware is built.
  - cmd 12 accepted in OP1, OP2 or RES goes directly to ERR (`status`=10) on the next cycle.
  - Add/sub behaviour is unchanged.

## Structure
- Package `calc_pkg` holds:
  - the command code enum (`CMD_ADD`=10 … `CMD_CLR`=15);
  - the state enum;
  - the status enum;
  - `MAG_W`=27;
  - the MAX_VAL function of DIGITS.
- Sub-module `calc_mul_seq`, compiled under `CALC_MUL_EN`:
  - ports `start`, `a`[MAG_W], `b`[MAG_W], `busy`, `done` (1-cycle pulse), `prod`[2·MAG_W];
  - shift-add, one bit per cycle.

## Test plan
1. Release `reset` with no commands → `value`=0, `status`=00, `cmd_ready`=1.
2. Enter 1,2,+,3,4,= → `status`=01 for one cycle, then `value`=46, `status`=11. A subsequent +,4,= chains to 50.
3. Enter 1,2,×,1,2,= under `CALC_MUL_EN` → `cmd_ready`=0 and `status`=01 for 28 cycles. A digit strobed mid-compute is dropped. Then `value`=144.
4. Enter nine 9s, then +,1,= → the ninth digit is ignored (A=99999999). The sum overflows: `status`=10, `value`=0. A digit is ignored; clear returns to `status`=00.
5. Enter 5,−,8,= → `value`=−3. Negate → 3. Entering digit 7 starts a new A=7 with `status`=00.
6. Assert `reset` during a multiply, mid-BUSY → asynchronous return to `value`=0, `status`=00. A rebuild without `CALC_MUL_EN` sends 2,× to `status`=10.
